// File: rtl/key_debounce_module_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings,
// default 50 MHz timing constants and a small press-counter helper.
package key_debounce_module_pkg;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } key_state_e;

  // 10 ms debounce window at 50 MHz
  localparam logic [18:0] T10MS_DEFAULT = 19'd500_000;
  // 1 s long-press threshold at 50 MHz
  localparam logic [25:0] TLONG_DEFAULT = 26'd50_000_000;

  // Press counter advances modulo 4; the 2-bit add wraps 3 -> 0 naturally
  function automatic logic [1:0] press_cnt_inc(input logic [1:0] cnt);
    return cnt + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce_module_sync2.sv
// Two-flop synchronizer for an asynchronous level input.
// RST_VAL sets the value both flops take in reset so an idle input
// (e.g. a pulled-up button) does not look like an event after reset.
module sync2_module #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= D;
      sync_r <= meta_r;
    end
  end

  assign Q = sync_r;

endmodule

// File: rtl/key_debounce_module.sv
// Debouncer for one active-low push-button. Produces registered
// press/release strobes, a debounced held level and a 2-bit wrapping
// press counter used downstream as a blink-mode select.
// Optional long-press strobe on KEY_LONG is built only when the macro
// KEY_LONG_PRESS_EN is defined; otherwise KEY_LONG is tied low.
module key_debounce_module
  import key_debounce_module_pkg::*;
#(
  parameter logic [18:0] T10MS = T10MS_DEFAULT,
  parameter logic [25:0] TLONG = TLONG_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       KEY_IN,
  output logic       KEY_PRESS,
  output logic       KEY_RELEASE,
  output logic       KEY_DOWN,
  output logic [1:0] PRESS_CNT,
  output logic       KEY_LONG
);

  logic        k_s;
  key_state_e  state_r;
  key_state_e  state_nxt_s;
  logic [18:0] cnt_r;
  logic [18:0] cnt_nxt_s;
  logic        press_nxt_s;
  logic        release_nxt_s;
  logic        down_nxt_s;
  logic [1:0]  press_cnt_nxt_s;
  logic        key_press_r;
  logic        key_release_r;
  logic        key_down_r;
  logic [1:0]  press_cnt_r;

  // Released button reads 1, so the synchronizer resets to 1
  sync2_module #(
    .RST_VAL (1'b1)
  ) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (KEY_IN),
    .Q     (k_s)
  );

  // FSM state and debounce counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= S_IDLE;
      cnt_r   <= 19'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and window counter: a level must hold for T10MS cycles
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (!k_s) begin
          state_nxt_s = S_PRESS_WAIT;
          cnt_nxt_s   = 19'd0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PRESS_WAIT: begin
        if (k_s) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 19'd0;
        end else if (cnt_r == T10MS - 19'd1) begin
          state_nxt_s = S_PRESSED;
        end else begin
          cnt_nxt_s   = cnt_r + 19'd1;
        end
      end
      S_PRESSED: begin
        if (k_s) begin
          state_nxt_s = S_RELEASE_WAIT;
          cnt_nxt_s   = 19'd0;
        end else begin
          state_nxt_s = S_PRESSED;
        end
      end
      S_RELEASE_WAIT: begin
        if (!k_s) begin
          state_nxt_s = S_PRESSED;
          cnt_nxt_s   = 19'd0;
        end else if (cnt_r == T10MS - 19'd1) begin
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r + 19'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 19'd0;
      end
    endcase
  end

  // Output decode: strobes fire only on the confirmed transitions
  always_comb begin
    press_nxt_s     = (state_r == S_PRESS_WAIT)   && (state_nxt_s == S_PRESSED);
    release_nxt_s   = (state_r == S_RELEASE_WAIT) && (state_nxt_s == S_IDLE);
    down_nxt_s      = (state_nxt_s == S_PRESSED) || (state_nxt_s == S_RELEASE_WAIT);
    if (press_nxt_s) begin
      press_cnt_nxt_s = press_cnt_inc(press_cnt_r);
    end else begin
      press_cnt_nxt_s = press_cnt_r;
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_press_r   <= 1'b0;
      key_release_r <= 1'b0;
      key_down_r    <= 1'b0;
      press_cnt_r   <= 2'd0;
    end else begin
      key_press_r   <= press_nxt_s;
      key_release_r <= release_nxt_s;
      key_down_r    <= down_nxt_s;
      press_cnt_r   <= press_cnt_nxt_s;
    end
  end

  assign KEY_PRESS   = key_press_r;
  assign KEY_RELEASE = key_release_r;
  assign KEY_DOWN    = key_down_r;
  assign PRESS_CNT   = press_cnt_r;

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] lcnt_r;
  logic [25:0] lcnt_nxt_s;
  logic        long_nxt_s;
  logic        key_long_r;

  // Hold-time counter: restarts on each confirmed press, stops one past
  // the threshold so only a single KEY_LONG can fire per press
  always_comb begin
    lcnt_nxt_s = lcnt_r;
    long_nxt_s = 1'b0;
    if (press_nxt_s || (state_nxt_s == S_IDLE)) begin
      lcnt_nxt_s = 26'd0;
    end else if ((state_r == S_PRESSED) || (state_r == S_RELEASE_WAIT)) begin
      if (lcnt_r == TLONG - 26'd1) begin
        long_nxt_s = 1'b1;
        lcnt_nxt_s = lcnt_r + 26'd1;
      end else if (lcnt_r < TLONG) begin
        lcnt_nxt_s = lcnt_r + 26'd1;
      end else begin
        lcnt_nxt_s = lcnt_r;
      end
    end else begin
      lcnt_nxt_s = lcnt_r;
    end
  end

  // Long-press counter and strobe registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lcnt_r     <= 26'd0;
      key_long_r <= 1'b0;
    end else begin
      lcnt_r     <= lcnt_nxt_s;
      key_long_r <= long_nxt_s;
    end
  end

  assign KEY_LONG = key_long_r;
`else
  // Threshold has no effect without the long-press logic
  logic unused_tlong_s;
  assign unused_tlong_s = ^TLONG;
  assign KEY_LONG       = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_module.sv
// Scoreboard bench for key_debounce_module with T10MS=20, TLONG=100.
// Stimulus pushes each expected strobe (kind, edge index, PRESS_CNT,
// KEY_DOWN) into a queue; a negedge monitor pops and compares whenever
// the DUT raises a strobe. Edge index = count of CLK rising edges.
module tb_key_debounce_module;

  localparam int T   = 20;
  localparam int LAT = T + 2;   // first low sample at edge N -> strobe after edge N+22
  localparam int TL  = 100;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       KEY_IN = 1'b1;
  logic       KEY_PRESS;
  logic       KEY_RELEASE;
  logic       KEY_DOWN;
  logic [1:0] PRESS_CNT;
  logic       KEY_LONG;

  typedef struct {
    int         kind;
    int         cyc;
    logic [1:0] cnt;
    logic       down;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [1:0] exp_cnt = 2'd0;

  key_debounce_module #(
    .T10MS (19'd20),
    .TLONG (26'd100)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .KEY_IN      (KEY_IN),
    .KEY_PRESS   (KEY_PRESS),
    .KEY_RELEASE (KEY_RELEASE),
    .KEY_DOWN    (KEY_DOWN),
    .PRESS_CNT   (PRESS_CNT),
    .KEY_LONG    (KEY_LONG)
  );

  always #10 CLK = ~CLK;

  // Rising-edge index used to time strobes
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_evt(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL unexpected_strobe: kind %0d at edge %0d, expected none", kind, cyc);
    end else begin
      e = sb_q.pop_front();
      chk("evt_kind", kind, e.kind);
      chk("evt_edge", cyc, e.cyc);
      chk("evt_press_cnt", {30'd0, PRESS_CNT}, {30'd0, e.cnt});
      chk("evt_key_down", {31'd0, KEY_DOWN}, {31'd0, e.down});
    end
  endtask

  // Monitor: compare every strobe the DUT presents against the scoreboard
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (KEY_PRESS === 1'b1 || KEY_RELEASE === 1'b1)
        chk("strobe_overlap", {31'd0, KEY_PRESS & KEY_RELEASE}, 32'd0);
      if (KEY_PRESS === 1'b1)   mon_evt(EV_PRESS);
      if (KEY_RELEASE === 1'b1) mon_evt(EV_RELEASE);
      if (KEY_LONG !== 1'b0)    mon_evt(EV_LONG);
    end
  end

  // Called at a negedge: drive level v for n rising edges
  task automatic hold(input logic v, input int n);
    KEY_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input int kind, input int dly, input logic down);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + 1 + dly;
    e.cnt  = exp_cnt;
    e.down = down;
    sb_q.push_back(e);
  endtask

  task automatic clean_press(input int len);
    exp_cnt = exp_cnt + 2'd1;
    push(EV_PRESS, LAT, 1'b1);
    hold(1'b0, len);
  endtask

  task automatic clean_release(input int len);
    push(EV_RELEASE, LAT, 1'b0);
    hold(1'b1, len);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_press"},   {31'd0, KEY_PRESS},   32'd0);
    chk({tag, "_release"}, {31'd0, KEY_RELEASE}, 32'd0);
    chk({tag, "_down"},    {31'd0, KEY_DOWN},    32'd0);
    chk({tag, "_cnt"},     {30'd0, PRESS_CNT},   32'd0);
    chk({tag, "_long"},    {31'd0, KEY_LONG},    32'd0);
  endtask

  logic [1:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 2'd3;
    wrap_seq[1] = 2'd0;
    wrap_seq[2] = 2'd1;
    wrap_seq[3] = 2'd2;

    // Reset state
    RST_N  = 1'b0;
    KEY_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST_N = 1'b1;
    hold(1'b1, 5);

    // Bounce: three 10-cycle low glitches are rejected
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 10);
      hold(1'b1, 10);
    end
    hold(1'b1, 20);
    chk("bounce_key_down", {31'd0, KEY_DOWN}, 32'd0);
    chk("bounce_press_cnt", {30'd0, PRESS_CNT}, 32'd0);

    // Clean press held 50 cycles
    clean_press(50);
    chk("press_key_down", {31'd0, KEY_DOWN}, 32'd1);
    chk("press_cnt_1", {30'd0, PRESS_CNT}, 32'd1);

    // Release with bounce: high 5, low 3, then high 30
    hold(1'b1, 5);
    hold(1'b0, 3);
    chk("release_bounce_down", {31'd0, KEY_DOWN}, 32'd1);
    clean_release(30);
    chk("release_key_down", {31'd0, KEY_DOWN}, 32'd0);

    // Press counter continues 2 -> 3 -> 0 -> 1 -> 2
    clean_press(30);
    chk("cnt_2", {30'd0, PRESS_CNT}, 32'd2);
    clean_release(30);
    for (int i = 0; i < 4; i++) begin
      clean_press(30);
      chk("wrap_cnt", {30'd0, PRESS_CNT}, {30'd0, wrap_seq[i]});
      clean_release(30);
    end

    // Reset in the middle of PRESS_WAIT with the key still low
    hold(1'b0, 13);
    RST_N = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge CLK);
    exp_cnt = 2'd0;
    RST_N = 1'b1;
    clean_press(30);
    chk("post_reset_cnt", {30'd0, PRESS_CNT}, 32'd1);
    clean_release(30);

    // Long hold of 150 cycles
    exp_cnt = exp_cnt + 2'd1;
    push(EV_PRESS, LAT, 1'b1);
`ifdef KEY_LONG_PRESS_EN
    push(EV_LONG, LAT + TL, 1'b1);
`endif
    hold(1'b0, 150);
    chk("long_key_down", {31'd0, KEY_DOWN}, 32'd1);
    clean_release(30);

    hold(1'b1, 10);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
